pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Parametrised pipeline sequencer for the pipeRV32N core. It generalises the global enable, nop and if-address-mode logic to NUM_STAGES stages.
- Adds prioritised per-stage redirect and bubble requests, a run/halt/step/error state machine, error-source capture, and performance counters.
- Sits at core top level between the stage done/request lines and the stage enable/nop/addr_mode inputs.

Parameters:
- NUM_STAGES, 4, pipeline stages; index 0 = IF, index NUM_STAGES-1 = WB/MEM (oldest).
- MODE_WIDTH, 2, width of IF address-mode code; code 0 = PC+4.
- CNT_WIDTH, 16, width of each performance counter.
- RESET_HALTED, 0, 1 = leave reset in HALT, 0 = leave reset in RUN.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- stage_done  in  NUM_STAGES  per-stage done.
- stage_error  in  NUM_STAGES  per-stage error-stop request.
- redirect_req  in  NUM_STAGES  per-stage PC redirect request; bit 0 ignored.
- redirect_mode  in  NUM_STAGES*MODE_WIDTH  requested IF mode; slice k belongs to stage k.
- bubble_req  in  NUM_STAGES  per-stage bubble (stall-insert) request.
- halt_req, resume_req, step_req, clear_error, cnt_clr  in  1 each  debug controls.
- stage_enable  out  NUM_STAGES  advance strobe; all bits identical.
- stage_nop  out  NUM_STAGES  load bubble on this advance.
- if_addr_mode  out  MODE_WIDTH  IF next-address mode.
- redirect_grant  out  NUM_STAGES  one-hot winning redirect source; selects imm/reg address mux.
- halted  out  1  state == HALT.
- error_halt  out  1  state == ERROR.
- error_stage  out  clog2(NUM_STAGES)  index of the oldest erroring stage.
- adv_cnt, stall_cnt, flush_cnt  out  CNT_WIDTH each  performance counters.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = HALT if RESET_HALTED else RUN.
  - error_stage = 0; all counters = 0.
  - stage_enable = 0; combinational outputs follow the reset state.
- all_done = AND(stage_done). any_err = OR(stage_error).

States:
- RUN:
  - adv = all_done & ~any_err & ~halt_req.
  - any_err → ERROR. Otherwise halt_req → HALT.
- HALT:
  - adv = 0.
  - resume_req → RUN (wins over step_req). Otherwise step_req → STEP.
  - any_err ignored.
- STEP:
  - adv = all_done & ~any_err.
  - any_err → ERROR. adv → HALT. Otherwise stay; waits for all_done.
- ERROR:
  - adv = 0.
  - clear_error → HALT. Sticky otherwise.
- On entry to ERROR, error_stage latches the highest index k with stage_error[k]=1.
- Encoding is internal. halted and error_halt are registered decodes of the state.

Outputs:
- stage_enable = {NUM_STAGES{adv}}, combinational.
- Redirect winner: highest k≥1 with redirect_req[k]=1.
  - redirect_grant = one-hot(k).
  - if_addr_mode = redirect_mode slice k.
  - stage_nop[j] = 1 for 1≤j≤k-1; bit 0 = 0 (IF fetches the new target).
- No redirect, bubble present: winner = highest k with bubble_req[k]=1.
  - stage_nop[j] = 1 for 0≤j≤k.
  - if_addr_mode = 0; redirect_grant = 0.
- Neither request: stage_nop = 0, if_addr_mode = 0, redirect_grant = 0.
- Redirect beats bubble. Older (higher index) beats younger.
- nop, mode and grant outputs are combinational and independent of state; stages sample them only when stage_enable=1.

Counters (synchronous, priority cnt_clr > increment):
- adv_cnt: +1 per cycle with adv=1; wraps.
- stall_cnt: +1 per cycle in RUN or STEP with all_done=0; saturates at all-ones.
- flush_cnt: +1 per cycle with adv=1 and any redirect_req[k≥1]; saturates.

Boundary conditions:
- halt_req and an error in the same RUN cycle → ERROR.
- reset asserted mid-STEP → reset state; no partial step.
- stage_done drops in the same cycle as step_req → STEP waits without timeout.
- Counters hold in HALT and ERROR.

Test Plan:
- Reset with RESET_HALTED=0, all stage_done=1, no requests → stage_enable=4'b1111 every cycle, stage_nop=0, if_addr_mode=0; adv_cnt=10 after 10 cycles.
- redirect_req=4'b1010, bubble_req[1]=1, redirect_mode slice3=2, slice1=1 → redirect_grant=4'b1000, if_addr_mode=2, stage_nop=4'b0110; flush_cnt +1.
- bubble_req=4'b0010 only → stage_nop=4'b0011, if_addr_mode=0, redirect_grant=0.
- In RUN: stage_done[2]=0 for 3 cycles → stage_enable=0 and stall_cnt=3. Then halt_req pulse → halted=1 next cycle, enable=0. step_req → exactly one cycle with enable=1 (all done), then halted=1 again, adv_cnt +1.
- stage_error=4'b0101 in RUN → enable=0 that cycle, error_halt=1, error_stage=2. resume_req ignored. clear_error → halted=1. resume_req → RUN.
- Counter edges: force stall_cnt to 16'hFFFF → holds. cnt_clr together with adv → adv_cnt=0. Asynchronous reset low mid-STEP → enable=0 immediately, counters=0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: global advance strobe, prioritised redirect/bubble
// steering, run/halt/step/error control, error capture and perf counters.
module pipe_ctrl #(
   parameter int NUM_STAGES   = 4,
   parameter int MODE_WIDTH   = 2,
   parameter int CNT_WIDTH    = 16,
   parameter bit RESET_HALTED = 1'b0
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_STAGES-1:0]              stage_done,
   input  logic [NUM_STAGES-1:0]              stage_error,
   input  logic [NUM_STAGES-1:0]              redirect_req,
   input  logic [NUM_STAGES*MODE_WIDTH-1:0]   redirect_mode,
   input  logic [NUM_STAGES-1:0]              bubble_req,
   input  logic                               halt_req,
   input  logic                               resume_req,
   input  logic                               step_req,
   input  logic                               clear_error,
   input  logic                               cnt_clr,
   output logic [NUM_STAGES-1:0]              stage_enable,
   output logic [NUM_STAGES-1:0]              stage_nop,
   output logic [MODE_WIDTH-1:0]              if_addr_mode,
   output logic [NUM_STAGES-1:0]              redirect_grant,
   output logic                               halted,
   output logic                               error_halt,
   output logic [$clog2(NUM_STAGES)-1:0]      error_stage,
   output logic [CNT_WIDTH-1:0]               adv_cnt,
   output logic [CNT_WIDTH-1:0]               stall_cnt,
   output logic [CNT_WIDTH-1:0]               flush_cnt
);

   localparam int SW = $clog2(NUM_STAGES);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HALT  = 2'd1,
      ST_STEP  = 2'd2,
      ST_ERROR = 2'd3
   } state_t;

   localparam state_t RST_STATE = RESET_HALTED ? ST_HALT : ST_RUN;

   state_t          r_state;
   state_t          w_next;
   logic            w_all_done;
   logic            w_any_err;
   logic            w_adv;
   logic [SW-1:0]   w_err_idx;
   logic            w_rd_hit;
   logic            w_bb_hit;
   int              w_rd_idx;
   int              w_bb_idx;
   logic            r_halted;
   logic            r_err_halt;
   logic [SW-1:0]   r_err_stage;
   logic [CNT_WIDTH-1:0] r_adv_cnt;
   logic [CNT_WIDTH-1:0] r_stall_cnt;
   logic [CNT_WIDTH-1:0] r_flush_cnt;

   // Advance decision and next-state selection
   always_comb begin
      w_all_done = &stage_done;
      w_any_err  = |stage_error;
      w_adv      = 1'b0;
      w_next     = r_state;
      case (r_state)
         ST_RUN: begin
            w_adv = w_all_done & ~w_any_err & ~halt_req;
            if (w_any_err)     w_next = ST_ERROR;
            else if (halt_req) w_next = ST_HALT;
            else               w_next = ST_RUN;
         end
         ST_HALT: begin
            if (resume_req)    w_next = ST_RUN;
            else if (step_req) w_next = ST_STEP;
            else               w_next = ST_HALT;
         end
         ST_STEP: begin
            w_adv = w_all_done & ~w_any_err;
            if (w_any_err)     w_next = ST_ERROR;
            else if (w_adv)    w_next = ST_HALT;
            else               w_next = ST_STEP;
         end
         ST_ERROR: begin
            if (clear_error)   w_next = ST_HALT;
            else               w_next = ST_ERROR;
         end
         default: begin
            w_next = RST_STATE;
         end
      endcase
      // enable must drop the instant reset asserts, even mid-step
      stage_enable = {NUM_STAGES{w_adv & reset}};
   end

   // Oldest-wins selection of error, redirect and bubble sources
   always_comb begin
      w_err_idx = {SW{1'b0}};
      w_rd_hit  = 1'b0;
      w_rd_idx  = 0;
      w_bb_hit  = 1'b0;
      w_bb_idx  = 0;
      for (int k = 0; k < NUM_STAGES; k++) begin
         w_err_idx = stage_error[k] ? SW'(k) : w_err_idx;
         w_rd_idx  = (redirect_req[k] && k != 0) ? k : w_rd_idx;
         w_rd_hit  = w_rd_hit | (redirect_req[k] && k != 0);
         w_bb_idx  = bubble_req[k] ? k : w_bb_idx;
         w_bb_hit  = w_bb_hit | bubble_req[k];
      end
   end

   // Steering of nop/mode/grant outputs from the winning request
   always_comb begin
      stage_nop      = {NUM_STAGES{1'b0}};
      redirect_grant = {NUM_STAGES{1'b0}};
      if_addr_mode   = {MODE_WIDTH{1'b0}};
      if (w_rd_hit) begin
         redirect_grant[w_rd_idx] = 1'b1;
         if_addr_mode = redirect_mode[w_rd_idx*MODE_WIDTH +: MODE_WIDTH];
         for (int j = 0; j < NUM_STAGES; j++) begin
            stage_nop[j] = (j >= 1) && (j < w_rd_idx);
         end
      end else if (w_bb_hit) begin
         for (int j = 0; j < NUM_STAGES; j++) begin
            stage_nop[j] = (j <= w_bb_idx);
         end
      end else begin
         stage_nop = {NUM_STAGES{1'b0}};
      end
   end

   // State, status decodes, error capture and performance counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= RST_STATE;
         r_halted    <= RESET_HALTED;
         r_err_halt  <= 1'b0;
         r_err_stage <= {SW{1'b0}};
         r_adv_cnt   <= {CNT_WIDTH{1'b0}};
         r_stall_cnt <= {CNT_WIDTH{1'b0}};
         r_flush_cnt <= {CNT_WIDTH{1'b0}};
      end else begin
         r_state    <= w_next;
         r_halted   <= (w_next == ST_HALT);
         r_err_halt <= (w_next == ST_ERROR);
         if (r_state != ST_ERROR && w_next == ST_ERROR) r_err_stage <= w_err_idx;
         else                                           r_err_stage <= r_err_stage;
         if (cnt_clr) begin
            r_adv_cnt   <= {CNT_WIDTH{1'b0}};
            r_stall_cnt <= {CNT_WIDTH{1'b0}};
            r_flush_cnt <= {CNT_WIDTH{1'b0}};
         end else begin
            if (w_adv) r_adv_cnt <= r_adv_cnt + CNT_WIDTH'(1);
            else       r_adv_cnt <= r_adv_cnt;
            if ((r_state == ST_RUN || r_state == ST_STEP) && !w_all_done && r_stall_cnt != {CNT_WIDTH{1'b1}})
               r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
            else
               r_stall_cnt <= r_stall_cnt;
            if (w_adv && w_rd_hit && r_flush_cnt != {CNT_WIDTH{1'b1}})
               r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
            else
               r_flush_cnt <= r_flush_cnt;
         end
      end
   end

   assign halted      = r_halted;
   assign error_halt  = r_err_halt;
   assign error_stage = r_err_stage;
   assign adv_cnt     = r_adv_cnt;
   assign stall_cnt   = r_stall_cnt;
   assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table, hand sequences
// for multi-cycle corners, and random stimulus against a behavioural model.
module tb_pipe_ctrl;

   localparam int M_RUN = 0, M_HALT = 1, M_STEP = 2, M_ERR = 3;

   logic clk, reset;
   logic [3:0] done, err, rreq, breq;
   logic [7:0] rmode;
   logic halt, resume, step, clr_err, cnt_clr;
   logic [3:0] stage_enable, stage_nop, redirect_grant;
   logic [1:0] if_addr_mode, error_stage;
   logic halted, error_halt;
   logic [15:0] adv_cnt, stall_cnt, flush_cnt;

   int n_tests = 0, n_fail = 0;
   int m_st, m_adv, m_stall, m_flush, m_estage;

   pipe_ctrl #(.NUM_STAGES(4), .MODE_WIDTH(2), .CNT_WIDTH(16), .RESET_HALTED(1'b0)) dut (
      .clk(clk), .reset(reset), .stage_done(done), .stage_error(err),
      .redirect_req(rreq), .redirect_mode(rmode), .bubble_req(breq),
      .halt_req(halt), .resume_req(resume), .step_req(step),
      .clear_error(clr_err), .cnt_clr(cnt_clr),
      .stage_enable(stage_enable), .stage_nop(stage_nop), .if_addr_mode(if_addr_mode),
      .redirect_grant(redirect_grant), .halted(halted), .error_halt(error_halt),
      .error_stage(error_stage), .adv_cnt(adv_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected combinational outputs derived from the priority rules
   task automatic model_comb(output logic [3:0] en, output logic [3:0] nop,
                             output logic [3:0] gr, output logic [1:0] md,
                             output bit adv, output int rk);
      bit all_d, any_e;
      int bk;
      all_d = (done == 4'hF);
      any_e = (err != 4'h0);
      adv = 1'b0;
      if (m_st == M_RUN)  adv = all_d && !any_e && !halt;
      if (m_st == M_STEP) adv = all_d && !any_e;
      en = (adv && reset) ? 4'hF : 4'h0;
      rk = -1;
      bk = -1;
      for (int k = 3; k >= 1; k--) if (rreq[k] && rk < 0) rk = k;
      for (int k = 3; k >= 0; k--) if (breq[k] && bk < 0) bk = k;
      if (rk > 0) begin
         gr  = 4'(1 << rk);
         md  = 2'((int'(rmode) >> (2 * rk)) & 3);
         nop = 4'(((1 << rk) - 1) & ~1);
      end else if (bk >= 0) begin
         gr = 4'h0; md = 2'd0; nop = 4'((1 << (bk + 1)) - 1);
      end else begin
         gr = 4'h0; md = 2'd0; nop = 4'h0;
      end
   endtask

   task automatic model_reset();
      m_st = M_RUN; m_adv = 0; m_stall = 0; m_flush = 0; m_estage = 0;
   endtask

   // One clock: check comb outputs, advance model and check registered outputs
   task automatic cyc(input bit do_chk);
      logic [3:0] en, nop, gr;
      logic [1:0] md;
      bit adv, all_d, any_e;
      int rk, nst, hi_err;
      #2;
      model_comb(en, nop, gr, md, adv, rk);
      if (do_chk) begin
         chk("enable", 32'(stage_enable), 32'(en));
         chk("nop", 32'(stage_nop), 32'(nop));
         chk("grant", 32'(redirect_grant), 32'(gr));
         chk("mode", 32'(if_addr_mode), 32'(md));
      end
      all_d = (done == 4'hF);
      any_e = (err != 4'h0);
      hi_err = 0;
      for (int k = 0; k < 4; k++) if (err[k]) hi_err = k;
      nst = m_st;
      case (m_st)
         M_RUN:  if (any_e) nst = M_ERR; else if (halt) nst = M_HALT;
         M_HALT: if (resume) nst = M_RUN; else if (step) nst = M_STEP;
         M_STEP: if (any_e) nst = M_ERR; else if (adv) nst = M_HALT;
         default: if (clr_err) nst = M_HALT;
      endcase
      if (nst == M_ERR && m_st != M_ERR) m_estage = hi_err;
      if (cnt_clr) begin
         m_adv = 0; m_stall = 0; m_flush = 0;
      end else begin
         if (adv) m_adv = (m_adv + 1) % 65536;
         if ((m_st == M_RUN || m_st == M_STEP) && !all_d && m_stall < 65535) m_stall++;
         if (adv && rk > 0 && m_flush < 65535) m_flush++;
      end
      m_st = nst;
      @(posedge clk);
      #1;
      if (do_chk) begin
         chk("halted", 32'(halted), 32'(m_st == M_HALT));
         chk("error_halt", 32'(error_halt), 32'(m_st == M_ERR));
         chk("error_stage", 32'(error_stage), 32'(m_estage));
         chk("adv_cnt", 32'(adv_cnt), 32'(m_adv));
         chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
         chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      chk("rst_enable", 32'(stage_enable), 32'h0);
      chk("rst_adv", 32'(adv_cnt), 32'h0);
      chk("rst_stall", 32'(stall_cnt), 32'h0);
      chk("rst_flush", 32'(flush_cnt), 32'h0);
      chk("rst_halted", 32'(halted), 32'h0);
      chk("rst_estage", 32'(error_stage), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
   endtask

   typedef struct {
      logic [3:0] rreq;
      logic [3:0] breq;
      logic [7:0] rmode;
      logic [3:0] e_nop;
      logic [3:0] e_grant;
      logic [1:0] e_mode;
   } vec_t;

   vec_t tbl[9];

   initial begin
      tbl[0] = '{4'b1010, 4'b0010, 8'h84, 4'b0110, 4'b1000, 2'd2};
      tbl[1] = '{4'b0000, 4'b0010, 8'h00, 4'b0011, 4'b0000, 2'd0};
      tbl[2] = '{4'b0000, 4'b0000, 8'hFF, 4'b0000, 4'b0000, 2'd0};
      tbl[3] = '{4'b0001, 4'b0000, 8'h03, 4'b0000, 4'b0000, 2'd0};
      tbl[4] = '{4'b0010, 4'b0000, 8'h0C, 4'b0000, 4'b0010, 2'd3};
      tbl[5] = '{4'b0100, 4'b0000, 8'h10, 4'b0010, 4'b0100, 2'd1};
      tbl[6] = '{4'b0000, 4'b1000, 8'h00, 4'b1111, 4'b0000, 2'd0};
      tbl[7] = '{4'b0000, 4'b0001, 8'h00, 4'b0001, 4'b0000, 2'd0};
      tbl[8] = '{4'b0110, 4'b1000, 8'h20, 4'b0010, 4'b0100, 2'd2};

      reset = 1'b0; done = 4'h0; err = 4'h0; rreq = 4'h0; breq = 4'h0; rmode = 8'h0;
      halt = 1'b0; resume = 1'b0; step = 1'b0; clr_err = 1'b0; cnt_clr = 1'b0;
      model_reset();
      @(negedge clk);
      do_reset();

      // Free run after reset
      done = 4'hF;
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1);
         chk("run_enable", 32'(stage_enable), 32'hF);
      end
      chk("adv_after_10", 32'(adv_cnt), 32'd10);

      // Steering vectors, all advancing in RUN
      for (int i = 0; i < 9; i++) begin
         rreq = tbl[i].rreq; breq = tbl[i].breq; rmode = tbl[i].rmode;
         #1;
         chk($sformatf("tbl%0d_nop", i), 32'(stage_nop), 32'(tbl[i].e_nop));
         chk($sformatf("tbl%0d_grant", i), 32'(redirect_grant), 32'(tbl[i].e_grant));
         chk($sformatf("tbl%0d_mode", i), 32'(if_addr_mode), 32'(tbl[i].e_mode));
         cyc(1'b1);
      end
      rreq = 4'h0; breq = 4'h0; rmode = 8'h0;
      chk("tbl_adv", 32'(adv_cnt), 32'd19);
      chk("tbl_flush", 32'(flush_cnt), 32'd4);

      // Stall, halt and single step
      done = 4'b1011;
      for (int i = 0; i < 3; i++) begin
         #1 chk("stall_enable", 32'(stage_enable), 32'h0);
         cyc(1'b1);
      end
      chk("stall_3", 32'(stall_cnt), 32'd3);
      done = 4'hF; halt = 1'b1;
      cyc(1'b1);
      halt = 1'b0;
      #1 chk("halt_halted", 32'(halted), 32'h1);
      chk("halt_enable", 32'(stage_enable), 32'h0);
      step = 1'b1;
      cyc(1'b1);
      step = 1'b0;
      #1 chk("step_enable", 32'(stage_enable), 32'hF);
      cyc(1'b1);
      chk("step_adv", 32'(adv_cnt), 32'd20);
      chk("step_halted", 32'(halted), 32'h1);
      chk("step_enable_off", 32'(stage_enable), 32'h0);

      // Error entry, sticky, clear, resume
      resume = 1'b1; cyc(1'b1); resume = 1'b0;
      err = 4'b0101;
      #1 chk("err_enable", 32'(stage_enable), 32'h0);
      cyc(1'b1);
      err = 4'h0;
      chk("err_halt", 32'(error_halt), 32'h1);
      chk("err_stage", 32'(error_stage), 32'd2);
      resume = 1'b1; cyc(1'b1); resume = 1'b0;
      chk("err_sticky", 32'(error_halt), 32'h1);
      clr_err = 1'b1; cyc(1'b1); clr_err = 1'b0;
      chk("clr_halted", 32'(halted), 32'h1);
      chk("clr_errhalt", 32'(error_halt), 32'h0);
      resume = 1'b1; cyc(1'b1); resume = 1'b0;
      chk("resume_run", 32'(halted), 32'h0);
      halt = 1'b1; err = 4'b1000; cyc(1'b1); halt = 1'b0; err = 4'h0;
      chk("halt_err_err", 32'(error_halt), 32'h1);
      chk("halt_err_stage", 32'(error_stage), 32'd3);
      clr_err = 1'b1; cyc(1'b1); clr_err = 1'b0;
      resume = 1'b1; cyc(1'b1); resume = 1'b0;

      // Clear beats increment, then stall saturation
      cnt_clr = 1'b1; cyc(1'b1); cnt_clr = 1'b0;
      chk("clr_adv", 32'(adv_cnt), 32'd0);
      done = 4'h0;
      for (int i = 0; i < 65534; i++) cyc(1'b0);
      chk("stall_fffe", 32'(stall_cnt), 32'hFFFE);
      for (int i = 0; i < 3; i++) cyc(1'b1);
      chk("stall_sat", 32'(stall_cnt), 32'hFFFF);

      // Reset while a step is waiting for all stages
      done = 4'hF; halt = 1'b1; cyc(1'b1); halt = 1'b0;
      done = 4'b0111; step = 1'b1; cyc(1'b1); step = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1);
         chk("step_wait", 32'(halted), 32'h0);
      end
      done = 4'hF;
      #1 chk("step_ready", 32'(stage_enable), 32'hF);
      do_reset();

      // Random traffic against the model
      for (int i = 0; i < 1500; i++) begin
         done    = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
         err     = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'h0;
         rreq    = 4'($urandom);
         breq    = 4'($urandom);
         rmode   = 8'($urandom);
         halt    = ($urandom_range(0, 9) == 0);
         resume  = ($urandom_range(0, 4) == 0);
         step    = ($urandom_range(0, 4) == 0);
         clr_err = ($urandom_range(0, 3) == 0);
         cnt_clr = ($urandom_range(0, 49) == 0);
         cyc(1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
